// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Module   : battleship_pkg
// Brief    : Shared button indices, default timing constants and the
//            press-pulse arbitration helper for the battleship input stage.
// Revision : 1.0 - initial release
// ============================================================================
package battleship_pkg;

    // Button channel indices (also the bit positions in btn_level)
    localparam int NUM_BTNS   = 7;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_SELECT = 4;
    localparam int BTN_START  = 5;
    localparam int BTN_RESET  = 6;

    // Default timing at 100 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;
    localparam int DEFAULT_REPEAT_RATE     = 15_000_000;

    typedef logic [NUM_BTNS-1:0] btn_vec_t;

    // Restart pulse wins over everything; directions are one-hot by
    // priority up > down > left > right; select/start pass alongside.
    function automatic btn_vec_t arbitrate(input btn_vec_t p);
        btn_vec_t g;
        g = '0;
        if (p[BTN_RESET]) begin
            g[BTN_RESET] = 1'b1;
        end else begin
            g[BTN_SELECT] = p[BTN_SELECT];
            g[BTN_START]  = p[BTN_START];
            if (p[BTN_UP])
                g[BTN_UP] = 1'b1;
            else if (p[BTN_DOWN])
                g[BTN_DOWN] = 1'b1;
            else if (p[BTN_LEFT])
                g[BTN_LEFT] = 1'b1;
            else if (p[BTN_RIGHT])
                g[BTN_RIGHT] = 1'b1;
        end
        return g;
    endfunction

endpackage : battleship_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : One button channel: 2-flop synchroniser, hold-time debounce
//            counter, debounced level and a one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import battleship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int                 c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_pulse;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_differ;
    logic               w_flip;
    logic               w_stable_next;
    logic [c_CNT_W-1:0] w_cnt_next;

    // Debounce decision: a new level is accepted only after it has held
    // for the full count; any agreement with the current level restarts it.
    always_comb begin
        w_differ      = (r_sync2 != r_stable);
        w_flip        = w_differ && (r_cnt == c_LIMIT);
        w_stable_next = w_flip ? ~r_stable : r_stable;
        w_cnt_next    = (!w_differ || w_flip) ? '0 : (r_cnt + c_ONE);
    end

    // Synchroniser, counter, stable level and rise pulse. Stable resets to
    // "pressed" so a button held through reset cannot produce a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b1;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_raw;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
            r_pulse  <= w_stable_next & ~r_stable;
            r_cnt    <= w_cnt_next;
        end
    end

    assign o_level = r_stable;
    assign o_pulse = r_pulse;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/battleship_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : battleship_btn_conditioner
// Brief    : Synchronises and debounces the seven board buttons, turns each
//            press into a single-cycle pulse and arbitrates the pulses so
//            restart masks everything and directions are mutually exclusive.
//            Optional direction auto-repeat is built when BTN_REPEAT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module battleship_btn_conditioner
    import battleship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_up,
    input  logic                raw_down,
    input  logic                raw_left,
    input  logic                raw_right,
    input  logic                raw_select,
    input  logic                raw_start,
    input  logic                raw_reset,
    output logic                btn_up,
    output logic                btn_down,
    output logic                btn_left,
    output logic                btn_right,
    output logic                btn_select,
    output logic                start_btn,
    output logic                reset_btn,
    output logic [NUM_BTNS-1:0] btn_level
);

    btn_vec_t w_raw;
    btn_vec_t w_level;
    btn_vec_t w_pulse;
    btn_vec_t w_src;
    btn_vec_t w_grant;

    assign w_raw[BTN_UP]     = raw_up;
    assign w_raw[BTN_DOWN]   = raw_down;
    assign w_raw[BTN_LEFT]   = raw_left;
    assign w_raw[BTN_RIGHT]  = raw_right;
    assign w_raw[BTN_SELECT] = raw_select;
    assign w_raw[BTN_START]  = raw_start;
    assign w_raw[BTN_RESET]  = raw_reset;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst     (reset),
            .i_raw   (w_raw[i]),
            .o_level (w_level[i]),
            .o_pulse (w_pulse[i])
        );
    end

`ifdef BTN_REPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
    localparam logic [c_RPT_W-1:0] c_DELAY = c_RPT_W'(REPEAT_DELAY);
    localparam logic [c_RPT_W-1:0] c_RATE  = c_RPT_W'(REPEAT_RATE);
    localparam logic [c_RPT_W-1:0] c_ONE   = c_RPT_W'(1);

    logic [3:0] w_rpt;

    // Direction channels occupy indices BTN_UP..BTN_RIGHT (0..3)
    for (genvar d = 0; d < 4; d++) begin : g_rpt
        logic [c_RPT_W-1:0] r_cnt;
        logic               r_run;
        logic               r_phase;
        logic               w_hit;

        // r_cnt counts cycles since the last press/repeat pulse; the
        // first target is the initial delay, afterwards the repeat rate.
        assign w_hit    = w_level[d] & r_run & (r_cnt == (r_phase ? c_RATE : c_DELAY));
        assign w_rpt[d] = w_hit;

        // Repeat timer: armed by the press pulse, cleared on release.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt   <= '0;
                r_run   <= 1'b0;
                r_phase <= 1'b0;
            end else if (!w_level[d]) begin
                r_cnt   <= '0;
                r_run   <= 1'b0;
                r_phase <= 1'b0;
            end else if (w_pulse[d]) begin
                r_cnt   <= c_ONE;
                r_run   <= 1'b1;
                r_phase <= 1'b0;
            end else if (r_run) begin
                if (w_hit) begin
                    r_cnt   <= c_ONE;
                    r_phase <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end
        end
    end

    assign w_src = w_pulse | btn_vec_t'(w_rpt);
`else
    assign w_src = w_pulse;

    // Without auto-repeat the REPEAT_* values have no effect; they are
    // only referenced so both builds expose the same parameter list.
    if (REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_rpt_unused
    end
`endif

    assign w_grant = arbitrate(w_src);

    assign btn_up     = w_grant[BTN_UP];
    assign btn_down   = w_grant[BTN_DOWN];
    assign btn_left   = w_grant[BTN_LEFT];
    assign btn_right  = w_grant[BTN_RIGHT];
    assign btn_select = w_grant[BTN_SELECT];
    assign start_btn  = w_grant[BTN_START];
    assign reset_btn  = w_grant[BTN_RESET];
    assign btn_level  = w_level;

endmodule : battleship_btn_conditioner
`default_nettype wire

// File: tb/tb_battleship_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_battleship_btn_conditioner
// Brief    : Table-driven bench for the button conditioner with a
//            cycle-tagged expectation queue, plus hand-written reset cases.
//            Auto-repeat expectations follow BTN_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_battleship_btn_conditioner;
    import battleship_pkg::*;

    localparam int c_DEB = 4;
    localparam int c_RD  = 10;
    localparam int c_RR  = 3;
`ifdef BTN_REPEAT_EN
    localparam bit c_REP = 1'b1;
`else
    localparam bit c_REP = 1'b0;
`endif

    // Bit masks in btn_level order
    localparam logic [6:0] c_U  = 7'b0000001;
    localparam logic [6:0] c_D  = 7'b0000010;
    localparam logic [6:0] c_L  = 7'b0000100;
    localparam logic [6:0] c_R  = 7'b0001000;
    localparam logic [6:0] c_S  = 7'b0010000;
    localparam logic [6:0] c_ST = 7'b0100000;
    localparam logic [6:0] c_RS = 7'b1000000;
    localparam logic [6:0] c_ALL = 7'h7F;

    typedef struct {
        logic [6:0] raw;
        logic [6:0] pulse;
        logic [6:0] lvl;
        logic [6:0] lmask;
    } vec_t;

    typedef struct {
        int         cyc;
        int         step;
        logic [6:0] pulse;
        logic [6:0] lvl;
        logic [6:0] lmask;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] raw = '0;
    logic       btn_up, btn_down, btn_left, btn_right, btn_select, start_btn, reset_btn;
    logic [6:0] btn_level;
    logic [6:0] w_out;

    vec_t  tbl[$];
    exp_t  sbq[$];
    exp_t  e;
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    string scen_name = "init";

    battleship_btn_conditioner #(
        .DEBOUNCE_CYCLES (c_DEB),
        .REPEAT_DELAY    (c_RD),
        .REPEAT_RATE     (c_RR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_up     (raw[0]),
        .raw_down   (raw[1]),
        .raw_left   (raw[2]),
        .raw_right  (raw[3]),
        .raw_select (raw[4]),
        .raw_start  (raw[5]),
        .raw_reset  (raw[6]),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_select (btn_select),
        .start_btn  (start_btn),
        .reset_btn  (reset_btn),
        .btn_level  (btn_level)
    );

    assign w_out = {reset_btn, start_btn, btn_select, btn_right, btn_left, btn_down, btn_up};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    // Monitor: compare the expectation tagged for the edge just taken
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            if (sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                chk($sformatf("%s[%0d]/pulse", scen_name, e.step), w_out, e.pulse);
                if (e.lmask != '0)
                    chk($sformatf("%s[%0d]/level", scen_name, e.step),
                        btn_level & e.lmask, e.lvl & e.lmask);
            end else if (sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s[%0d]/stale got none want check at edge %0d",
                         scen_name, e.step, e.cyc);
            end
        end
    end

    task automatic add_step(input logic [6:0] r, input logic [6:0] p,
                            input logic [6:0] l, input logic [6:0] m);
        tbl.push_back('{r, p, l, m});
    endtask

    // Called during the clock-low phase: each step is sampled at the next edge
    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            raw = tbl[i].raw;
            sbq.push_back('{cyc + 1, i, tbl[i].pulse, tbl[i].lvl, tbl[i].lmask});
            @(negedge clk);
        end
        #1;
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s/drain got %0d pending want 0", scen_name, sbq.size());
            sbq.delete();
        end
        tbl.delete();
    endtask

    // Asynchronous reset: outputs must clear with no clock edge
    task automatic do_reset(input logic [6:0] r);
        reset = 1'b1;
        raw   = r;
        #1;
        chk("reset/pulse", w_out, 7'h00);
        chk("reset/level", btn_level, c_ALL);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Idle buttons leave the "pressed" reset level without pulsing
    task automatic settle();
        scen_name = "settle";
        for (int k = 0; k < 10; k++)
            add_step('0, '0, (k < 3) ? c_ALL : 7'h00, (k < 3 || k >= 6) ? c_ALL : 7'h00);
        run_tbl();
    endtask

    // Press mask m for 'hold' cycles: level rises 6 edges after the first
    // sample and falls 6 edges after the release; pm pulses at step 6;
    // rpm repeats at step 16 then every 3 while the level is still high.
    task automatic scen(input string nm, input logic [6:0] m, input int hold,
                        input logic [6:0] pm, input logic [6:0] rpm, input int total);
        logic [6:0] p;
        scen_name = nm;
        for (int k = 0; k < total; k++) begin
            p = (k == c_DEB + 2) ? pm : 7'h00;
            if (rpm != '0 && k >= c_DEB + 2 + c_RD && k < hold + c_DEB + 2
                && ((k - (c_DEB + 2 + c_RD)) % c_RR) == 0)
                p = rpm;
            add_step((k < hold) ? m : 7'h00, p,
                     (k >= c_DEB + 2 && k < hold + c_DEB + 2) ? m : 7'h00, c_ALL);
        end
        run_tbl();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        do_reset('0);
        settle();

        scen("right_hold",   c_R,             12, c_R,        7'h00, 24);

        scen_name = "select_glitch";
        for (int k = 0; k < 36; k++)
            add_step((k < 30 && ((k / 3) % 2) == 0) ? c_S : 7'h00, '0, '0, c_ALL);
        run_tbl();

        scen("up_left",      c_U | c_L,        8, c_U,        7'h00, 20);
        scen("reset_select", c_RS | c_S,       8, c_RS,       7'h00, 20);
        scen("down_rt_sel",  c_D | c_R | c_S,  8, c_D | c_S,  7'h00, 20);
        scen("left_right",   c_L | c_R,        8, c_L,        7'h00, 20);
        scen("start_up",     c_ST | c_U,       8, c_ST | c_U, 7'h00, 20);

        // Down held across reset: no pulse until released and pressed again
        do_reset(c_D);
        scen_name = "down_held";
        for (int k = 0; k < 12; k++)
            add_step(c_D, '0, c_D, c_D);
        for (int k = 0; k < 10; k++)
            add_step('0, '0, (k < 6) ? c_D : 7'h00, c_ALL);
        run_tbl();
        scen("down_repress", c_D,              8, c_D,        7'h00, 20);

        // Reset mid-debounce aborts the press
        scen_name = "mid_reset";
        for (int k = 0; k < 3; k++)
            add_step(c_R, '0, '0, c_ALL);
        run_tbl();
        do_reset('0);
        settle();

        // Reset while a pulse is high clears it at once
        scen_name = "inflight";
        for (int k = 0; k < 7; k++)
            add_step(c_R, (k == 6) ? c_R : 7'h00, (k == 6) ? c_R : 7'h00, c_ALL);
        run_tbl();
        #1;
        do_reset('0);
        settle();

        scen("left_repeat",  c_L,             30, c_L, c_REP ? c_L : 7'h00, 44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_battleship_btn_conditioner
`default_nettype wire
